// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shifter gated by an enable tick (optional PISO_PARITY_EN appends even parity bit)
module piso_shift_register #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] d,
    input  logic         load,
    output logic         ready,
    input  logic         enable,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
`ifdef PISO_PARITY_EN
    logic           parity_q, parity_d;
`endif

    // State, datapath and registered done flag; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic plus output decode straight from registered state.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        ready        = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_d = d;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^d;
`endif
                end
            end
            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];
                if (enable) begin
                    if (cnt_q != '0) begin
                        // Move the next bit toward the output end, zero-filling behind it.
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_d   = cnt_q - CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_valid = 1'b1;
                serial_out   = parity_q;
                if (enable) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// tb/tb_piso_shift_register.sv - directed self-checking bench for piso_shift_register
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // DUT m: N=8, MSB first
    logic       m_reset, m_load, m_enable, m_ready, m_out, m_valid, m_done;
    logic [7:0] m_d;
    // DUT b: N=8, LSB first
    logic       b_reset, b_load, b_enable, b_ready, b_out, b_valid, b_done;
    logic [7:0] b_d;
    // DUT c: N=2, MSB first
    logic       c_reset, c_load, c_enable, c_ready, c_out, c_valid, c_done;
    logic [1:0] c_d;

    piso_shift_register #(.N(8), .MSB_FIRST(1'b1)) u_m (
        .clock(clock), .reset(m_reset), .d(m_d), .load(m_load), .ready(m_ready),
        .enable(m_enable), .serial_out(m_out), .serial_valid(m_valid), .done(m_done)
    );
    piso_shift_register #(.N(8), .MSB_FIRST(1'b0)) u_b (
        .clock(clock), .reset(b_reset), .d(b_d), .load(b_load), .ready(b_ready),
        .enable(b_enable), .serial_out(b_out), .serial_valid(b_valid), .done(b_done)
    );
    piso_shift_register #(.N(2), .MSB_FIRST(1'b1)) u_c (
        .clock(clock), .reset(c_reset), .d(c_d), .load(c_load), .ready(c_ready),
        .enable(c_enable), .serial_out(c_out), .serial_valid(c_valid), .done(c_done)
    );

    // Expected bit i of a transfer of the n-bit word w; index n is the parity bit.
    function automatic logic model_bit(input logic [7:0] w, input int i, input int n, input bit msb);
        if (i >= n) return ^w;
        if (msb) return w[n-1-i];
        return w[i];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        m_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        m_load = 1'b1; b_load = 1'b1; c_load = 1'b1;
        m_enable = 1'b1; b_enable = 1'b1; c_enable = 1'b1;
        m_d = 8'hFF; b_d = 8'hFF; c_d = 2'b11;
        tick();
        tick();
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", m_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        total++; if (m_out !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", m_out); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", m_done); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready got=%b exp=1", b_ready); end
        total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL reset_c_ready got=%b exp=1", c_ready); end
        m_load = 1'b0; b_load = 1'b0; c_load = 1'b0;
        m_enable = 1'b0; b_enable = 1'b0; c_enable = 1'b0;
        m_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", m_valid); end
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hA5;
        m_d = w; m_load = 1'b1; m_enable = 1'b1;
        tick();
        m_load = 1'b0;
        for (int i = 0; i < 8 + PAR; i++) begin
            total++; if (m_out !== model_bit(w, i, 8, 1'b1)) begin bad++; $display("FAIL msb_bit%0d got=%b exp=%b", i, m_out, model_bit(w, i, 8, 1'b1)); end
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL msb_valid%0d got=%b exp=1", i, m_valid); end
            total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL msb_ready%0d got=%b exp=0", i, m_ready); end
            total++; if (m_done !== 1'b0) begin bad++; $display("FAIL msb_early_done%0d got=%b exp=0", i, m_done); end
            tick();
        end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL msb_done got=%b exp=1", m_done); end
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL msb_end_ready got=%b exp=1", m_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL msb_end_valid got=%b exp=0", m_valid); end
        tick();
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL msb_done_pulse got=%b exp=0", m_done); end
        m_enable = 1'b0;
    endtask

    task automatic test_lsb_slow_enable();
        logic [7:0] w;
        w = 8'h01;
        b_d = w; b_load = 1'b1; b_enable = 1'b0;
        tick();
        b_load = 1'b0;
        b_d = 8'hFF;
        for (int i = 0; i < 8 + PAR; i++) begin
            for (int c = 0; c < 3; c++) begin
                total++; if (b_out !== model_bit(w, i, 8, 1'b0)) begin bad++; $display("FAIL lsb_bit%0d_c%0d got=%b exp=%b", i, c, b_out, model_bit(w, i, 8, 1'b0)); end
                total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid%0d_c%0d got=%b exp=1", i, c, b_valid); end
                b_enable = (c == 2);
                tick();
            end
        end
        total++; if (b_done !== 1'b1) begin bad++; $display("FAIL lsb_done got=%b exp=1", b_done); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL lsb_ready got=%b exp=1", b_ready); end
        tick();
        total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL idle_enable_valid got=%b exp=0", b_valid); end
        total++; if (b_done !== 1'b0) begin bad++; $display("FAIL idle_enable_done got=%b exp=0", b_done); end
        b_enable = 1'b0;
    endtask

    task automatic test_load_while_busy();
        logic [7:0] w;
        w = 8'hFF;
        m_d = w; m_load = 1'b1; m_enable = 1'b1;
        tick();
        m_load = 1'b0;
        for (int i = 0; i < 8 + PAR; i++) begin
            if (i == 2) begin m_load = 1'b1; m_d = 8'h00; end
            if (i == 3) m_load = 1'b0;
            total++; if (m_out !== model_bit(w, i, 8, 1'b1)) begin bad++; $display("FAIL busy_bit%0d got=%b exp=%b", i, m_out, model_bit(w, i, 8, 1'b1)); end
            total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL busy_ready%0d got=%b exp=0", i, m_ready); end
            tick();
        end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b exp=1", m_done); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL busy_requeued got=%b exp=0", m_valid); end
        m_enable = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] w;
        m_d = 8'hF0; m_load = 1'b1; m_enable = 1'b1;
        tick();
        m_load = 1'b0;
        tick(); tick(); tick();
        m_reset = 1'b1;
        tick();
        m_reset = 1'b0;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", m_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", m_valid); end
        total++; if (m_out !== 1'b0) begin bad++; $display("FAIL abort_out got=%b exp=0", m_out); end
        for (int k = 0; k < 10; k++) begin
            total++; if (m_done !== 1'b0) begin bad++; $display("FAIL abort_done%0d got=%b exp=0", k, m_done); end
            tick();
        end
        w = 8'h3C;
        m_d = w; m_load = 1'b1;
        tick();
        m_load = 1'b0;
        for (int i = 0; i < 8 + PAR; i++) begin
            total++; if (m_out !== model_bit(w, i, 8, 1'b1)) begin bad++; $display("FAIL after_abort_bit%0d got=%b exp=%b", i, m_out, model_bit(w, i, 8, 1'b1)); end
            tick();
        end
        total++; if (m_done !== 1'b1) begin bad++; $display("FAIL after_abort_done got=%b exp=1", m_done); end
        m_enable = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        c_enable = 1'b1;
        c_d = 2'b01; c_load = 1'b1;
        tick();
        c_load = 1'b0;
        for (int i = 0; i < 2 + PAR; i++) begin
            total++; if (c_out !== model_bit(8'h01, i, 2, 1'b1)) begin bad++; $display("FAIL b2b_w0_bit%0d got=%b exp=%b", i, c_out, model_bit(8'h01, i, 2, 1'b1)); end
            tick();
        end
        total++; if (c_done !== 1'b1) begin bad++; $display("FAIL b2b_done0 got=%b exp=1", c_done); end
        total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", c_ready); end
        c_d = 2'b10; c_load = 1'b1;
        tick();
        c_load = 1'b0;
        for (int i = 0; i < 2 + PAR; i++) begin
            total++; if (c_out !== model_bit(8'h02, i, 2, 1'b1)) begin bad++; $display("FAIL b2b_w1_bit%0d got=%b exp=%b", i, c_out, model_bit(8'h02, i, 2, 1'b1)); end
            total++; if (c_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b exp=1", i, c_valid); end
            tick();
        end
        total++; if (c_done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", c_done); end
        c_enable = 1'b0;
        tick();
    endtask

    task automatic test_parity_words();
        logic [7:0] words [2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        m_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_d = words[k]; m_load = 1'b1;
            tick();
            m_load = 1'b0;
            for (int i = 0; i < 8 + PAR; i++) begin
                total++; if (m_out !== model_bit(words[k], i, 8, 1'b1)) begin bad++; $display("FAIL word%0d_bit%0d got=%b exp=%b", k, i, m_out, model_bit(words[k], i, 8, 1'b1)); end
                total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL word%0d_valid%0d got=%b exp=1", k, i, m_valid); end
                tick();
            end
            total++; if (m_done !== 1'b1) begin bad++; $display("FAIL word%0d_done got=%b exp=1", k, m_done); end
            tick();
        end
        m_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_slow_enable();
        test_load_while_busy();
        test_reset_mid_transfer();
        test_back_to_back();
        test_parity_words();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
